// File: rtl/truth_table_sweep_ctrl.sv
// Sweeps all 2^N_IN input vectors through a combinational gate and checks its truth table.
// Define TTS_GRAY_ORDER_EN to apply vectors in Gray-code order instead of binary order.
module truth_table_sweep_ctrl #(
    parameter int unsigned              N_IN        = 4,
    parameter logic [(1 << N_IN) - 1:0] EXPECTED_TT = 16'h2FC7,
    parameter int unsigned              SETTLE_CYC  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [N_IN-1:0]          dut_in,
    input  logic                     dut_out,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [(1 << N_IN) - 1:0] captured_tt,
    output logic [N_IN:0]            mismatch_cnt,
    output logic [N_IN-1:0]          first_fail,
    output logic                     first_fail_vld
);

    localparam int unsigned     NVEC        = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(NVEC - 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
    localparam logic [N_IN:0]   CNT_ONE     = (N_IN + 1)'(1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q;
    logic [7:0]        settle_cnt_q;
    logic [N_IN-1:0]   cur_vec;
    logic              miss;

    function automatic logic [N_IN-1:0] vec(input logic [N_IN-1:0] i);
`ifdef TTS_GRAY_ORDER_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    assign cur_vec = vec(idx_q);
    assign miss    = (dut_out != EXPECTED_TT[cur_vec]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSettle;
            StSettle: if (settle_cnt_q == SETTLE_LAST) state_d = StSample;
            StSample: state_d = (idx_q == LAST_IDX) ? StDone : StSettle;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // Result registers hold the last sweep's outcome while idle; start is ignored outside StIdle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q          <= '0;
            settle_cnt_q   <= '0;
            dut_in         <= '0;
            pass           <= 1'b0;
            captured_tt    <= '0;
            mismatch_cnt   <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        idx_q          <= '0;
                        settle_cnt_q   <= '0;
                        dut_in         <= vec('0);
                        pass           <= 1'b0;
                        captured_tt    <= '0;
                        mismatch_cnt   <= '0;
                        first_fail     <= '0;
                        first_fail_vld <= 1'b0;
                    end
                end
                StSettle: settle_cnt_q <= settle_cnt_q + 8'd1;
                StSample: begin
                    captured_tt[cur_vec] <= dut_out;
                    if (miss) begin
                        mismatch_cnt <= mismatch_cnt + CNT_ONE;
                        if (!first_fail_vld) begin
                            first_fail     <= cur_vec;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        pass <= !miss && (mismatch_cnt == '0);
                    end else begin
                        idx_q        <= idx_q + IDX_ONE;
                        dut_in       <= vec(idx_q + IDX_ONE);
                        settle_cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
